mem_access_unit: RTL

Load/store initiator that sits between the CPU datapath and the 19-bit data memory. Accepts one byte or halfword load/store per valid/ready handshake, drives the memory's address, write-data, write-enable and size lines, captures the memory's combinational read data, and returns a sign- or zero-extended result with a one-cycle response pulse. Misaligned halfword accesses are split into two byte accesses when the split feature is compiled in.

---
 rtl/mem_access_pkg.sv | 8 +
 rtl/mem_access_unit_load_extend.sv | 17 +
 rtl/mem_access_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared widths, size encodings and FSM states for mem_access_unit
package mem_access_pkg;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 19;
    localparam logic SZ_BYTE = 1'b0;
    localparam logic SZ_HALF = 1'b1;
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
endpackage

// File: rtl/mem_access_unit_load_extend.sv
// load_extend: merges the two bytes of a split load and sign/zero-extends the result
module load_extend
    import mem_access_pkg::*;
(
    input  logic              half,
    input  logic              sgn,
    input  logic              merge,
    input  logic [7:0]        lo,
    input  logic [15:0]       rd,
    output logic [DATA_W-1:0] data
);
    logic [15:0] d;
    always_comb begin
        d = merge ? {rd[7:0], lo} : rd;
        data = half ? {{(DATA_W-16){sgn & d[15]}}, d} : {{(DATA_W-8){sgn & d[7]}}, d[7:0]};
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/halfword load-store initiator for the 19-bit data memory.
// Define MEM_ACCESS_SPLIT_EN to split misaligned halfwords into two byte accesses.
module mem_access_unit
    import mem_access_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_half,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    output logic              mem_cant_byte,
    input  logic [DATA_W-1:0] mem_rd
);
    state_t            state;
    logic              we_q, half_q, sgn_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [7:0]        lo_q;
    logic [DATA_W-1:0] ext;
    logic              mis, single, unused;
    assign unused = ^{mem_rd[DATA_W-1:16], req_wdata[DATA_W-1:16]};
    assign mis = half_q && addr_q[0];
    assign single = state == ACC0 && half_q && !mis;
    assign req_ready = state == IDLE && !reset;
    // reset gates the write strobe combinationally so an interrupted store never commits in that cycle
    assign mem_we = (state == ACC0 || state == ACC1) && we_q && !reset;
    always_comb begin
        mem_a = state == ACC0 ? addr_q : state == ACC1 ? addr_q + ADDR_W'(1) : '0;
        mem_cant_byte = single ? SZ_HALF : SZ_BYTE;
        mem_wd = single ? {3'b0, wdata_q} :
                 state == ACC0 ? {11'b0, wdata_q[7:0]} :
                 state == ACC1 ? {11'b0, wdata_q[15:8]} : '0;
    end
    load_extend u_ext (
        .half  (half_q),
        .sgn   (sgn_q),
        .merge (state == ACC1),
        .lo    (lo_q),
        .rd    (mem_rd[15:0]),
        .data  (ext)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            half_q    <= 1'b0;
            sgn_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lo_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    half_q  <= req_half;
                    sgn_q   <= req_signed;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata[15:0];
`ifdef MEM_ACCESS_SPLIT_EN
                    state   <= ACC0;
`else
                    if (req_half && req_addr[0]) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        state <= ACC0;
                    end
`endif
                end
                ACC0: begin
`ifdef MEM_ACCESS_SPLIT_EN
                    if (mis) begin
                        lo_q  <= mem_rd[7:0];
                        state <= ACC1;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= we_q ? '0 : ext;
                    end
`else
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= we_q ? '0 : ext;
`endif
                end
`ifdef MEM_ACCESS_SPLIT_EN
                ACC1: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= we_q ? '0 : ext;
                end
`endif
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
